// File: rtl/dump_pkg.sv
// Shared definitions for the dump strobe timing monitor: FSM states, read-select
// codes, default widths and status bit positions.
package dump_pkg;

    localparam int unsigned DEF_TIMER_W = 14;
    localparam int unsigned DEF_CNT_W   = 4;

    typedef enum logic [2:0] {
        StIdle,
        StWaitOn,
        StOn,
        StOff,
        StDone
    } state_e;

    localparam logic [2:0] SEL_FIRST_ON  = 3'd0;
    localparam logic [2:0] SEL_ON_WIDTH  = 3'd1;
    localparam logic [2:0] SEL_OFF_WIDTH = 3'd2;
    localparam logic [2:0] SEL_ON_COUNT  = 3'd3;
    localparam logic [2:0] SEL_END_TIME  = 3'd4;
    localparam logic [2:0] SEL_STATUS    = 3'd5;

    localparam int unsigned STAT_DONE = 0;
    localparam int unsigned STAT_OVL  = 1;
    localparam int unsigned STAT_TMO  = 2;
    localparam int unsigned STAT_SAT  = 3;

endpackage

// File: rtl/dump_width_counter.sv
// Saturating cycle counter with synchronous clear, count enable and freeze.
module dump_width_counter #(
    parameter int unsigned W = 14
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         frz_i,
    output logic [W-1:0] count_o
);

    localparam logic [W-1:0] CountMax = {W{1'b1}};

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i && !frz_i && (count_q != CountMax)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/dump_monitor.sv
// Decodes the dump on/off strobe sequence into onset delay, first on/off widths,
// pulse count and end time, readable through a registered select port.
module dump_monitor
    import dump_pkg::*;
#(
    parameter int unsigned TIMER_W = DEF_TIMER_W,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic        clkin,
    input  logic        reset,
    input  logic        start,
    input  logic        dumpon_str,
    input  logic        dumpoff_str,
    input  logic        over,
    input  logic [2:0]  rd_sel,
    output logic [15:0] dataout,
    output logic        done,
    output logic        err
);

    localparam logic [TIMER_W-1:0] TimerMax = {TIMER_W{1'b1}};
    localparam logic [CNT_W-1:0]   CntMax   = {CNT_W{1'b1}};

    state_e              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [TIMER_W-1:0]  first_on_q, first_on_d;
    logic [TIMER_W-1:0]  end_time_q, end_time_d;
    logic [CNT_W-1:0]    on_count_q, on_count_d;
    logic                ovl_q, ovl_d;
    logic                tmo_q, tmo_d;
    logic                sat_q, sat_d;
    logic                on_frz_q, on_frz_d;
    logic                off_frz_q, off_frz_d;
    logic                done_q, done_d;
    logic [15:0]         dataout_q, rd_data;
    logic [15:0]         status;
    logic                active;
    logic                wc_clr, on_en, off_en;
    logic [TIMER_W-1:0]  on_width, off_width;

    assign active = (state_q == StWaitOn) || (state_q == StOn) || (state_q == StOff);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        first_on_d = first_on_q;
        end_time_d = end_time_q;
        on_count_d = on_count_q;
        ovl_d      = ovl_q;
        tmo_d      = tmo_q;
        sat_d      = sat_q;
        on_frz_d   = on_frz_q;
        off_frz_d  = off_frz_q;
        done_d     = done_q;
        wc_clr     = 1'b0;
        on_en      = 1'b0;
        off_en     = 1'b0;

        if (start) begin
            state_d    = StWaitOn;
            timer_d    = '0;
            first_on_d = '0;
            end_time_d = '0;
            on_count_d = '0;
            ovl_d      = 1'b0;
            tmo_d      = 1'b0;
            sat_d      = 1'b0;
            on_frz_d   = 1'b0;
            off_frz_d  = 1'b0;
            done_d     = 1'b0;
            wc_clr     = 1'b1;
        end else if (active) begin
            if (dumpon_str && dumpoff_str) begin
                ovl_d = 1'b1;
            end
            if (timer_q != TimerMax) begin
                timer_d = timer_q + TIMER_W'(1);
            end

            if (!over) begin
                end_time_d = timer_q;
                state_d    = StDone;
                done_d     = 1'b1;
            end else if (timer_q == TimerMax) begin
                tmo_d      = 1'b1;
                end_time_d = timer_q;
                state_d    = StDone;
                done_d     = 1'b1;
            end else begin
                unique case (state_q)
                    StWaitOn: begin
                        if (dumpon_str) begin
                            first_on_d = timer_q;
                            on_count_d = on_count_q + CNT_W'(1);
                            on_en      = 1'b1;
                            state_d    = StOn;
                        end
                    end
                    StOn: begin
                        if (dumpon_str) begin
                            on_en = 1'b1;
                        end else begin
                            // The falling cycle already belongs to the off phase.
                            off_en   = dumpoff_str;
                            on_frz_d = 1'b1;
                            state_d  = StOff;
                        end
                    end
                    StOff: begin
                        // An overlapping cycle is not taken as a new on pulse.
                        if (dumpon_str && !dumpoff_str) begin
                            if (on_count_q == CntMax) begin
                                sat_d = 1'b1;
                            end else begin
                                on_count_d = on_count_q + CNT_W'(1);
                            end
                            off_frz_d = 1'b1;
                            state_d   = StOn;
                        end else begin
                            off_en = dumpoff_str;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            first_on_q <= '0;
            end_time_q <= '0;
            on_count_q <= '0;
            ovl_q      <= 1'b0;
            tmo_q      <= 1'b0;
            sat_q      <= 1'b0;
            on_frz_q   <= 1'b0;
            off_frz_q  <= 1'b0;
            done_q     <= 1'b0;
            dataout_q  <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            first_on_q <= first_on_d;
            end_time_q <= end_time_d;
            on_count_q <= on_count_d;
            ovl_q      <= ovl_d;
            tmo_q      <= tmo_d;
            sat_q      <= sat_d;
            on_frz_q   <= on_frz_d;
            off_frz_q  <= off_frz_d;
            done_q     <= done_d;
            dataout_q  <= rd_data;
        end
    end

    dump_width_counter #(
        .W (TIMER_W)
    ) u_on_width (
        .clk_i   (clkin),
        .rst_i   (reset),
        .clr_i   (wc_clr),
        .en_i    (on_en),
        .frz_i   (on_frz_q),
        .count_o (on_width)
    );

    dump_width_counter #(
        .W (TIMER_W)
    ) u_off_width (
        .clk_i   (clkin),
        .rst_i   (reset),
        .clr_i   (wc_clr),
        .en_i    (off_en),
        .frz_i   (off_frz_q),
        .count_o (off_width)
    );

    always_comb begin
        status            = '0;
        status[STAT_DONE] = done_q;
        status[STAT_OVL]  = ovl_q;
        status[STAT_TMO]  = tmo_q;
        status[STAT_SAT]  = sat_q;
    end

    always_comb begin
        rd_data = '0;
        case (rd_sel)
            SEL_FIRST_ON:  rd_data = 16'(first_on_q);
            SEL_ON_WIDTH:  rd_data = 16'(on_width);
            SEL_OFF_WIDTH: rd_data = 16'(off_width);
            SEL_ON_COUNT:  rd_data = 16'(on_count_q);
            SEL_END_TIME:  rd_data = 16'(end_time_q);
            SEL_STATUS:    rd_data = status;
            default:       rd_data = '0;
        endcase
    end

    assign dataout = dataout_q;
    assign done    = done_q;
    assign err     = ovl_q | tmo_q;

endmodule

// File: tb/tb_dump_monitor.sv
// Self-checking bench for dump_monitor: directed strobe traces indexed by timer value,
// a trace-scanning model of the results, and a per-cycle compare process.
module tb_dump_monitor;

    localparam int MAXT = 16383;

    logic        clkin = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        dumpon_str = 1'b0;
    logic        dumpoff_str = 1'b0;
    logic        over = 1'b1;
    logic [2:0]  rd_sel = 3'd0;
    logic [15:0] dataout;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    bit          ton [0:MAXT];
    bit          toff [0:MAXT];
    bit          tover [0:MAXT];
    logic [15:0] exp_res [0:7];
    logic        exp_done = 1'b0;
    logic        exp_err = 1'b0;
    bit          chk_en = 1'b0;
    logic [2:0]  sel_s = 3'd0;

    always #5 clkin = ~clkin;

    dump_monitor dut (
        .clkin       (clkin),
        .reset       (reset),
        .start       (start),
        .dumpon_str  (dumpon_str),
        .dumpoff_str (dumpoff_str),
        .over        (over),
        .rd_sel      (rd_sel),
        .dataout     (dataout),
        .done        (done),
        .err         (err)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    always @(posedge clkin) sel_s <= rd_sel;

    // dataout reflects the select sampled at the previous edge.
    always @(negedge clkin) begin
        if (chk_en) begin
            chk($sformatf("dataout sel%0d", sel_s), dataout, exp_res[sel_s]);
            chk("done", {15'd0, done}, {15'd0, exp_done});
            chk("err", {15'd0, err}, {15'd0, exp_err});
        end
    end

    task automatic clear_trace();
        for (int i = 0; i <= MAXT; i++) begin
            ton[i] = 1'b0;
            toff[i] = 1'b0;
            tover[i] = 1'b1;
        end
    endtask

    task automatic set_on(input int a, input int b);
        for (int i = a; i <= b; i++) ton[i] = 1'b1;
    endtask

    task automatic set_off(input int a, input int b);
        for (int i = a; i <= b; i++) toff[i] = 1'b1;
    endtask

    task automatic set_end(input int t);
        for (int i = t; i <= MAXT; i++) tover[i] = 1'b0;
    endtask

    task automatic nominal_trace();
        clear_trace();
        set_on(10, 19);
        set_off(20, 29);
        set_on(30, 39);
        set_off(40, 49);
        set_on(50, 59);
        set_end(60);
    endtask

    task automatic zero_model();
        for (int i = 0; i < 8; i++) exp_res[i] = 16'h0000;
        exp_done = 1'b0;
        exp_err = 1'b0;
    endtask

    // Results from a scan of the whole trace, pulse by pulse.
    task automatic model();
        int end_t, rises, first, onw, offw, phase;
        bit tmo, ovl, in_on, found;
        end_t = MAXT; found = 0; tmo = 0; ovl = 0;
        for (int t = 0; t <= MAXT; t++) begin
            if (!tover[t]) begin
                end_t = t;
                found = 1;
                break;
            end
        end
        if (!found) tmo = 1;
        for (int t = 0; t <= end_t; t++) if (ton[t] && toff[t]) ovl = 1;
        rises = 0; first = 0; onw = 0; offw = 0; phase = 0; in_on = 0;
        for (int t = 0; t < end_t; t++) begin
            if (phase == 0) begin
                if (ton[t]) begin
                    first = t; rises = 1; onw = 1; phase = 1; in_on = 1;
                end
            end else if (in_on) begin
                if (ton[t]) begin
                    if (phase == 1) onw++;
                end else begin
                    in_on = 0;
                    if (phase == 1) phase = 2;
                    if (phase == 2 && toff[t]) offw++;
                end
            end else if (ton[t] && !toff[t]) begin
                rises++; in_on = 1; phase = 3;
            end else if (phase == 2 && toff[t]) begin
                offw++;
            end
        end
        exp_res[0] = 16'(first);
        exp_res[1] = 16'(onw);
        exp_res[2] = 16'(offw);
        exp_res[3] = 16'((rises > 15) ? 15 : rises);
        exp_res[4] = 16'(end_t);
        exp_res[5] = {12'd0, (rises > 15), tmo, ovl, 1'b1};
        exp_res[6] = 16'h0000;
        exp_res[7] = 16'h0000;
        exp_done = 1'b1;
        exp_err = ovl | tmo;
    endtask

    task automatic do_start();
        dumpon_str = 1'b0; dumpoff_str = 1'b0; over = 1'b1;
        start = 1'b1;
        @(posedge clkin); #1;
        start = 1'b0;
    endtask

    task automatic drive(input int a, input int b);
        for (int t = a; t <= b; t++) begin
            dumpon_str = ton[t]; dumpoff_str = toff[t]; over = tover[t];
            @(posedge clkin); #1;
        end
    endtask

    task automatic wait_done(input int limit);
        bit seen = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clkin);
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk("done_wait_timeout", {15'd0, done}, 16'd1);
    endtask

    // Sweep the select port with strobes wiggling; results must hold.
    task automatic read_phase();
        @(posedge clkin); #1;
        chk_en = 1'b1;
        for (int s = 0; s < 8; s++) begin
            rd_sel = 3'(s);
            @(posedge clkin); #1;
        end
        for (int i = 0; i < 10; i++) begin
            rd_sel = 3'($urandom_range(0, 7));
            dumpon_str = 1'($urandom_range(0, 1));
            dumpoff_str = 1'($urandom_range(0, 1));
            over = 1'($urandom_range(0, 1));
            @(posedge clkin); #1;
        end
        @(negedge clkin); #1;
        chk_en = 1'b0;
        dumpon_str = 1'b0; dumpoff_str = 1'b0; over = 1'b1;
    endtask

    task automatic lit(input logic [2:0] sel, input logic [15:0] val, input string name);
        rd_sel = sel;
        @(posedge clkin);
        @(negedge clkin);
        chk(name, dataout, val);
    endtask

    initial begin
        // Reset state
        zero_model();
        repeat (3) @(posedge clkin);
        #1 reset = 1'b0;
        read_phase();
        lit(3'd5, 16'h0000, "reset_status");

        // Nominal sequence
        nominal_trace();
        model();
        do_start();
        drive(0, 60);
        wait_done(50);
        read_phase();
        lit(3'd0, 16'd10, "nom_first_on");
        lit(3'd1, 16'd10, "nom_on_width");
        lit(3'd2, 16'd10, "nom_off_width");
        lit(3'd3, 16'd3, "nom_on_count");
        rd_sel = 3'd4;
        #1 chk("nom_latency_hold", dataout, 16'd3);
        @(posedge clkin);
        @(negedge clkin);
        chk("nom_end_time", dataout, 16'd60);
        lit(3'd5, 16'h0001, "nom_status");
        lit(3'd6, 16'h0000, "sel6");
        lit(3'd7, 16'h0000, "sel7");

        // Overlap at timer 25
        nominal_trace();
        ton[25] = 1'b1;
        model();
        do_start();
        drive(0, 60);
        wait_done(50);
        read_phase();
        lit(3'd5, 16'h0003, "ovl_status");
        lit(3'd3, 16'd3, "ovl_on_count");
        lit(3'd2, 16'd10, "ovl_off_width");
        chk("ovl_err", {15'd0, err}, 16'd1);

        // Count saturation: 20 pulses of 3 cycles
        clear_trace();
        for (int k = 0; k < 20; k++) begin
            set_on(5 + 6 * k, 7 + 6 * k);
            set_off(8 + 6 * k, 10 + 6 * k);
        end
        set_end(125);
        model();
        do_start();
        drive(0, 125);
        wait_done(50);
        read_phase();
        lit(3'd3, 16'd15, "sat_on_count");
        lit(3'd5, 16'h0009, "sat_status");

        // Restart at timer 35, then a fresh nominal run
        nominal_trace();
        model();
        do_start();
        drive(0, 34);
        do_start();
        drive(0, 60);
        wait_done(50);
        read_phase();
        lit(3'd0, 16'd10, "rst_first_on");
        lit(3'd4, 16'd60, "rst_end_time");

        // Reset at timer 35
        do_start();
        drive(0, 34);
        reset = 1'b1;
        @(posedge clkin); #1;
        reset = 1'b0;
        zero_model();
        read_phase();
        lit(3'd0, 16'd0, "rmid_first_on");
        lit(3'd5, 16'd0, "rmid_status");
        chk("rmid_done", {15'd0, done}, 16'd0);

        // Timeout
        clear_trace();
        ton[5] = 1'b1;
        model();
        do_start();
        drive(0, MAXT);
        wait_done(20);
        read_phase();
        lit(3'd4, 16'h3FFF, "tmo_end_time");
        lit(3'd5, 16'h0005, "tmo_status");
        lit(3'd0, 16'd5, "tmo_first_on");
        chk("tmo_done", {15'd0, done}, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
